// File: rtl/histo_readout_seq_pkg.sv
// Shared types and constants for the histogram readout sequencer.
// The sequencer scans a channel range and streams a channel-number header plus the histogram words of each channel.
package histo_readout_seq_pkg;

    localparam int DEF_NCHAN      = 64;
    localparam int DEF_NHIST      = 8;
    localparam int BYTES_PER_CHAN = 1 + 4 * DEF_NHIST;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_CAPTURE,
        S_HEADER,
        S_SEND,
        S_CLEAR,
        S_NEXT,
        S_DONE
    } state_t;

    // Size of one channel packet: one header byte, then four bytes for each histogram word.
    function automatic int bytes_per_chan(input int nhist);
        return 1 + 4 * nhist;
    endfunction

endpackage

// File: rtl/hist_word_serializer.sv
// Captures one channel's histogram words and sends them as a valid/ready byte stream.
// Byte order is the channel header, then word 0 upward, with each word least-significant byte first.
module hist_word_serializer
    import histo_readout_seq_pkg::*;
#(
    parameter int NHIST = DEF_NHIST
) (
    input  logic                  clk_adc,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [7:0]            chan,
    input  logic [32*NHIST-1:0]   histosin,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  hdr_ack,
    output logic                  last_ack
);

    localparam int NDATA = bytes_per_chan(NHIST) - 1;
    localparam int DW    = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam logic [DW-1:0] LAST_IDX = DW'(NDATA - 1);

    logic [7:0]    byte_buf [NDATA];
    logic          hdr_phase;
    logic [DW-1:0] data_idx;
    logic [DW-1:0] idx_next;
    logic          handshake;

    assign handshake = tx_valid && tx_ready;
    assign idx_next  = data_idx + 1'b1;
    assign hdr_ack   = handshake && hdr_phase;
    assign last_ack  = handshake && !hdr_phase && (data_idx == LAST_IDX);

    // The capture buffer is pure datapath; it is always loaded before it is read, so it needs no reset.
    always_ff @(posedge clk_adc) begin
        if (capture) begin
            for (int b = 0; b < NDATA; b++) begin
                byte_buf[b] <= histosin[8*b +: 8];
            end
        end
    end

    // The output register changes only on capture or on a handshake, so the byte holds while the consumer stalls.
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
            hdr_phase <= 1'b0;
            data_idx  <= '0;
        end else if (capture) begin
            tx_valid  <= 1'b1;
            tx_data   <= chan;
            hdr_phase <= 1'b1;
            data_idx  <= '0;
        end else if (handshake) begin
            if (hdr_phase) begin
                hdr_phase <= 1'b0;
                tx_data   <= byte_buf[0];
            end else if (data_idx == LAST_IDX) begin
                tx_valid  <= 1'b0;
            end else begin
                data_idx  <= idx_next;
                tx_data   <= byte_buf[idx_next];
            end
        end
    end

endmodule

// File: rtl/histo_readout_seq.sv
// Scan sequencer: for each channel it selects the channel, waits for the datapath to settle, and captures the histograms.
// It then streams the captured data and can clear the channel's histograms before moving to the next channel.
module histo_readout_seq
    import histo_readout_seq_pkg::*;
#(
    parameter int NCHAN  = DEF_NCHAN,
    parameter int NHIST  = DEF_NHIST,
    parameter int SETTLE = 3,
    parameter int CLRCYC = 3
) (
    input  logic                clk_adc,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          first_chan,
    input  logic [7:0]          last_chan,
    input  logic                clear_after_read,
    input  logic [32*NHIST-1:0] histosin,
    output logic [7:0]          histostosend,
    output logic                resethist,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] CLR_LAST    = 8'(CLRCYC - 1);

    state_t     state, state_n;
    logic [7:0] chan;
    logic [7:0] last_q;
    logic       clear_q;
    logic [7:0] settle_cnt;
    logic [7:0] clr_cnt;
    logic       rej_q;
    logic       range_ok;
    logic       hdr_ack;
    logic       last_ack;

    assign range_ok  = (first_chan <= last_chan) && (32'(last_chan) < NCHAN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) || rej_q;
    assign resethist = (state == S_CLEAR);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start && range_ok) state_n = S_SELECT;
            S_SELECT:  state_n = S_WAIT;
            S_WAIT:    if (settle_cnt == SETTLE_LAST) state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_HEADER;
            S_HEADER:  if (hdr_ack) state_n = S_SEND;
            S_SEND:    if (last_ack) state_n = clear_q ? S_CLEAR : S_NEXT;
            S_CLEAR:   if (clr_cnt == CLR_LAST) state_n = S_NEXT;
            S_NEXT:    state_n = (chan == last_q) ? S_DONE : S_SELECT;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // A rejected range leaves the FSM in IDLE; rej_q supplies the done pulse for that case.
    // The channel never increments past last_q, so the counter cannot wrap.
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            chan         <= 8'd0;
            last_q       <= 8'd0;
            clear_q      <= 1'b0;
            settle_cnt   <= 8'd0;
            clr_cnt      <= 8'd0;
            histostosend <= 8'd0;
            err          <= 1'b0;
            rej_q        <= 1'b0;
        end else begin
            state <= state_n;
            rej_q <= 1'b0;
            if (state == S_IDLE && start) begin
                if (range_ok) begin
                    chan    <= first_chan;
                    last_q  <= last_chan;
                    clear_q <= clear_after_read;
                    err     <= 1'b0;
                end else begin
                    err     <= 1'b1;
                    rej_q   <= 1'b1;
                end
            end
            if (state == S_SELECT) histostosend <= chan;
            settle_cnt <= (state == S_WAIT)  ? settle_cnt + 8'd1 : 8'd0;
            clr_cnt    <= (state == S_CLEAR) ? clr_cnt + 8'd1    : 8'd0;
            if (state == S_NEXT && chan != last_q) chan <= chan + 8'd1;
        end
    end

    hist_word_serializer #(
        .NHIST(NHIST)
    ) u_serializer (
        .clk_adc  (clk_adc),
        .rst      (rst),
        .capture  (state == S_CAPTURE),
        .chan     (chan),
        .histosin (histosin),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .hdr_ack  (hdr_ack),
        .last_ack (last_ack)
    );

endmodule

// File: tb/tb_histo_readout_seq.sv
// Directed bench for histo_readout_seq with a byte scoreboard and a histogram source that settles in three cycles.
// The histogram source is modelled as a three-stage delay on histostosend.
module tb_histo_readout_seq;

    localparam int NCHAN = 64;
    localparam int NHIST = 8;

    logic                clk_adc;
    logic                rst;
    logic                start;
    logic [7:0]          first_chan;
    logic [7:0]          last_chan;
    logic                clear_after_read;
    logic [32*NHIST-1:0] histosin;
    logic [7:0]          histostosend;
    logic                resethist;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                busy;
    logic                done;
    logic                err;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         byte_cnt = 0;
    int         done_cnt = 0;
    int         rh_cycles = 0;
    bit         rand_ready = 0;
    bit         chk_clear_chan = 0;
    logic [7:0] rh_chan = 8'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] exp_q [$];
    logic [7:0] hs_d1, hs_d2, hs_d3;

    histo_readout_seq #(
        .NCHAN(NCHAN), .NHIST(NHIST), .SETTLE(3), .CLRCYC(3)
    ) dut (
        .clk_adc          (clk_adc),
        .rst              (rst),
        .start            (start),
        .first_chan       (first_chan),
        .last_chan        (last_chan),
        .clear_after_read (clear_after_read),
        .histosin         (histosin),
        .histostosend     (histostosend),
        .resethist        (resethist),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clk_adc = 1'b0;
    always #5 clk_adc = ~clk_adc;

    function automatic logic [31:0] patWord(input int c, input int k);
        logic [7:0] cb, kb;
        cb = 8'(c);
        kb = 8'(k);
        return {cb, kb, 8'(c * 7 + k * 13 + 1), cb ^ {kb[3:0], 4'h0} ^ 8'h5A};
    endfunction

    always @(posedge clk_adc) begin
        hs_d1 <= histostosend;
        hs_d2 <= hs_d1;
        hs_d3 <= hs_d2;
    end

    always_comb begin
        histosin = '0;
        for (int k = 0; k < NHIST; k++) histosin[32*k +: 32] = patWord(int'(hs_d3), k);
    end

    always @(posedge clk_adc) begin
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes are checked against the scoreboard at the falling edge before the edge that accepts them.
    always @(negedge clk_adc) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(tx_valid), 32'd1);
                checkOutput("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                byte_cnt++;
                checkOutput("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) checkOutput("byte_value", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            if (resethist) begin
                rh_cycles++;
                if (chk_clear_chan) checkOutput("clear_chan", 32'(histostosend), 32'(rh_chan));
            end
            if (done) done_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic resetCounters();
        byte_cnt  = 0;
        done_cnt  = 0;
        rh_cycles = 0;
    endtask

    task automatic applyStimulus(input int f, input int l, input bit clr);
        logic [31:0] w;
        @(posedge clk_adc);
        #1;
        first_chan       = 8'(f);
        last_chan        = 8'(l);
        clear_after_read = clr;
        if (f <= l && l < NCHAN) begin
            for (int c = f; c <= l; c++) begin
                exp_q.push_back(8'(c));
                for (int k = 0; k < NHIST; k++) begin
                    w = patWord(c, k);
                    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
                end
            end
        end
        start = 1'b1;
        @(posedge clk_adc);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_adc);
            #1;
            if (done_cnt != 0) break;
        end
        repeat (4) @(negedge clk_adc);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_histostosend"}, 32'(histostosend), 32'd0);
        checkOutput({tag, "_resethist"}, 32'(resethist), 32'd0);
        checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        first_chan = 8'd0;
        last_chan = 8'd0;
        clear_after_read = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk_adc);
        checkResetValues("reset");
        rst = 1'b0;

        $display("[TB] full scan 0..63, no clear, ready held high");
        resetCounters();
        applyStimulus(0, 63, 0);
        waitDone(5000);
        checkOutput("full_done", 32'(done_cnt), 32'd1);
        checkOutput("full_bytes", 32'(byte_cnt), 32'd2112);
        checkOutput("full_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("full_no_clear", 32'(rh_cycles), 32'd0);
        checkOutput("full_busy_low", 32'(busy), 32'd0);

        $display("[TB] single channel 5 with clear");
        resetCounters();
        chk_clear_chan = 1'b1;
        rh_chan = 8'd5;
        applyStimulus(5, 5, 1);
        waitDone(500);
        chk_clear_chan = 1'b0;
        checkOutput("ch5_done", 32'(done_cnt), 32'd1);
        checkOutput("ch5_bytes", 32'(byte_cnt), 32'd33);
        checkOutput("ch5_clear_cycles", 32'(rh_cycles), 32'd3);
        checkOutput("ch5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] full scan with random ready");
        resetCounters();
        rand_ready = 1'b1;
        applyStimulus(0, 63, 0);
        waitDone(12000);
        rand_ready = 1'b0;
        checkOutput("rand_done", 32'(done_cnt), 32'd1);
        checkOutput("rand_bytes", 32'(byte_cnt), 32'd2112);
        checkOutput("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] rejected range 10..3");
        resetCounters();
        applyStimulus(10, 3, 0);
        repeat (5) @(negedge clk_adc);
        #1;
        checkOutput("rej_err", 32'(err), 32'd1);
        checkOutput("rej_done", 32'(done_cnt), 32'd1);
        checkOutput("rej_bytes", 32'(byte_cnt), 32'd0);
        checkOutput("rej_busy", 32'(busy), 32'd0);
        resetCounters();
        applyStimulus(2, 3, 0);
        checkOutput("rej_err_cleared", 32'(err), 32'd0);
        waitDone(1000);
        checkOutput("rej_next_done", 32'(done_cnt), 32'd1);
        checkOutput("rej_next_bytes", 32'(byte_cnt), 32'd66);

        $display("[TB] reset during clear of channel 2");
        resetCounters();
        applyStimulus(0, 5, 1);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_adc);
            #1;
            if (resethist && histostosend == 8'd2) break;
        end
        checkOutput("reach_clear_ch2", 32'(resethist && histostosend == 8'd2), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("async_rst");
        repeat (3) @(negedge clk_adc);
        checkOutput("rst_no_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        resetCounters();
        applyStimulus(0, 1, 1);
        waitDone(1000);
        checkOutput("post_rst_done", 32'(done_cnt), 32'd1);
        checkOutput("post_rst_bytes", 32'(byte_cnt), 32'd66);
        checkOutput("post_rst_clear_cycles", 32'(rh_cycles), 32'd6);

        $display("[TB] start pulsed mid-scan");
        resetCounters();
        applyStimulus(20, 25, 0);
        repeat (60) @(posedge clk_adc);
        #1;
        first_chan = 8'd0;
        last_chan  = 8'd63;
        start = 1'b1;
        @(posedge clk_adc);
        #1;
        start = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        waitDone(2000);
        checkOutput("mid_done", 32'(done_cnt), 32'd1);
        checkOutput("mid_bytes", 32'(byte_cnt), 32'd198);
        checkOutput("mid_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("mid_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/histo_readout_seq.md
HISTO_READOUT_SEQ -- requirements
Module: histo_readout_seq

Interface
REQ-001 Parameter NCHAN, default 64, number of trigger input channels scanned.
REQ-002 Parameter NHIST, default 8, histogram words per channel.
REQ-003 Parameter SETTLE, default 3, clk_adc cycles from histostosend change to valid histosin.
REQ-004 Parameter CLRCYC, default 3, cycles resethist is held per cleared channel.
REQ-005 clk_adc  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 start  in  1  single-cycle request to begin a scan.
REQ-008 first_chan  in  8  first channel to scan, latched on accepted start.
REQ-009 last_chan  in  8  last channel to scan (inclusive), latched on accepted start.
REQ-010 clear_after_read  in  1  clear each channel's histograms after capture, latched on accepted start.
REQ-011 histosin  in  32*NHIST  histogram words for the selected channel; word k is bits [32k+31:32k].
REQ-012 histostosend  out  8  channel select driven to the histogram datapath.
REQ-013 resethist  out  1  histogram clear strobe for the selected channel.
REQ-014 tx_data  out  8  outgoing byte.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  consumer accepts the byte when tx_valid and tx_ready are both high.
REQ-017 busy  out  1  high from accepted start until DONE exits.
REQ-018 done  out  1  one-cycle pulse at scan completion.
REQ-019 err  out  1  sticky; set on rejected range; cleared by the next accepted start.

Function
REQ-020 States: IDLE, SELECT, WAIT, CAPTURE, HEADER, SEND, CLEAR, NEXT, DONE.
REQ-021 IDLE: start accepted only in IDLE; start while busy is ignored, with no other effect.
REQ-022 Valid range: first_chan<=last_chan<NCHAN; otherwise set err, pulse done, and stay IDLE with no bytes sent.
REQ-023 SELECT: drive histostosend=current channel; go to WAIT.
REQ-024 WAIT: count SETTLE cycles with histostosend held; go to CAPTURE.
REQ-025 CAPTURE: register all NHIST words into an internal buffer in one cycle; go to HEADER.
REQ-026 HEADER: present one byte equal to the channel number; advance on handshake; go to SEND.
REQ-027 SEND: present NHIST*4 bytes: word 0 first, each word least-significant byte first; advance one byte per handshake.
REQ-028 tx_valid and tx_data SHALL stay stable while tx_valid=1 and tx_ready=0; tx_valid never drops before handshake.
REQ-029 After the last byte: if clear_after_read is latched go to CLEAR, else go to NEXT.
REQ-030 CLEAR: resethist=1 for exactly CLRCYC cycles with histostosend held; go to NEXT.
REQ-031 NEXT: if channel==last_chan go to DONE, else increment channel and go to SELECT.
REQ-032 DONE: pulse done for one cycle, deassert busy, return to IDLE.
REQ-033 Bytes per scan = (last_chan-first_chan+1)*(1+4*NHIST); for 64 channels with NHIST=8 that is 2112 bytes.
REQ-034 Channel counter is 8 bits and SHALL NOT wrap; scan terminates at last_chan=NCHAN-1.
REQ-035 resethist is 0 in every state except CLEAR.
REQ-036 histostosend holds its last value in IDLE.

Reset
REQ-037 rst=1 asynchronously forces IDLE and sets histostosend=0, resethist=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0.
REQ-038 rst mid-scan abandons the scan, including mid-CLEAR; resethist drops immediately; no done pulse is generated.

Structure
REQ-039 A shared package holds the state enum, BYTES_PER_CHAN=1+4*NHIST, and the default NCHAN and NHIST values.
REQ-040 One sub-module, hist_word_serializer, holds the capture buffer, the byte index, and the valid/ready output stage.

Verification
REQ-041 first=0, last=63, clear=0, tx_ready held 1 -> 2112 bytes; header bytes 0..63 in order; histosin pattern reproduced byte-exact; one done pulse; resethist never high.
REQ-042 first=5, last=5, clear=1 -> 33 bytes; resethist high for exactly 3 cycles with histostosend=5; then done.
REQ-043 tx_ready toggled randomly at 50% -> byte stream identical to REQ-041; tx_data never changes while stalled.
REQ-044 first=10, last=3 -> err=1, done pulse, zero bytes sent; a following valid start clears err.
REQ-045 rst asserted during CLEAR of channel 2 -> all outputs reach reset values asynchronously; no done pulse; a new start runs normally.
REQ-046 start pulsed again mid-scan -> ignored; total byte count unchanged.
